sqrt_arbiter: RTL and testbench

- Round-robin arbiter that shares one iterative integer square-root unit among NUM_REQ requesters.
- Latches the winning request and issues a one-cycle start pulse to the sqrt unit.
- Waits for the sqrt unit's one-cycle result pulse, then returns the result tagged with the requester index.
- Sits between pixel/physics clients and a single sqrt instance. One operation is in flight at a time.

---
 rtl/sqrt_arbiter_if.sv | 33 +++
 rtl/sqrt_arbiter.sv | 119 +++++++++++
 tb/tb_sqrt_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_arbiter_if.sv
// Bundle of request, sqrt-unit and response signals shared by the arbiter and its clients.
// The slave modport is the arbiter's view; master is the client/sqrt-unit side.
interface sqrt_arbiter_if #(
   parameter int WIDTH   = 12,
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid_in;
   logic [NUM_REQ*WIDTH-1:0] req_x_in;
   logic [NUM_REQ-1:0]       req_ready_out;
   logic [WIDTH-1:0]         sqrt_x_out;
   logic                     sqrt_valid_out;
   logic [WIDTH-1:0]         sqrt_result_in;
   logic                     sqrt_result_valid_in;
   logic                     resp_valid_out;
   logic [WIDTH-1:0]         resp_data_out;
   logic [ID_W-1:0]          resp_id_out;
   logic                     resp_err_out;
   logic                     busy_out;

   modport master (
      output req_valid_in, req_x_in, sqrt_result_in, sqrt_result_valid_in,
      input  req_ready_out, sqrt_x_out, sqrt_valid_out,
      input  resp_valid_out, resp_data_out, resp_id_out, resp_err_out, busy_out
   );

   modport slave (
      input  req_valid_in, req_x_in, sqrt_result_in, sqrt_result_valid_in,
      output req_ready_out, sqrt_x_out, sqrt_valid_out,
      output resp_valid_out, resp_data_out, resp_id_out, resp_err_out, busy_out
   );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative sqrt unit among NUM_REQ requesters, one op in flight.
// Optional WAIT watchdog enabled by defining SQRT_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrate; accept winner, latch operand and id
// ISSUE | one-cycle start pulse to the sqrt unit
// WAIT  | hold operand until the result pulse (or watchdog expiry)
// RESP  | one-cycle response pulse tagged with requester id
module sqrt_arbiter #(
   parameter int WIDTH          = 12,
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic           clk_in,
   input logic           rst_in,
   sqrt_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, id_q, resp_id_q;
   logic [ID_W-1:0] grant_idx;
   logic            grant_found;
   logic            accept;
   logic            finish;
   logic            timeout_hit;
   logic [WIDTH-1:0] x_q, data_q;

   // First requester after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin : rr_search
      logic [ID_W-1:0] cand;
      cand        = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!grant_found && bus.req_valid_in[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Gated by reset so a requester never sees an accept that the reset discards.
   assign accept = (state_q == IDLE) && grant_found && !rst_in;
   assign finish = (state_q == WAIT) && (bus.sqrt_result_valid_in || timeout_hit);

`ifdef SQRT_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer_q;
   logic          err_q;

   always_ff @(posedge clk_in) begin
      if (rst_in || state_q != WAIT) timer_q <= '0;
      else                           timer_q <= timer_q + 1'b1;
   end

   assign timeout_hit = (state_q == WAIT) && (timer_q == TW'(TIMEOUT_CYCLES - 1));

   // A real result on the limit cycle wins over the timeout.
   always_ff @(posedge clk_in) begin
      if (rst_in)      err_q <= 1'b0;
      else if (finish) err_q <= !bus.sqrt_result_valid_in;
   end

   assign bus.resp_err_out = err_q;
`else
   logic unused_timeout;
   assign unused_timeout   = ^TIMEOUT_CYCLES;
   assign timeout_hit      = 1'b0;
   assign bus.resp_err_out = 1'b0;
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_found) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (bus.sqrt_result_valid_in || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rr_ptr_q  <= ID_W'(NUM_REQ - 1);
         id_q      <= '0;
         x_q       <= '0;
         data_q    <= '0;
         resp_id_q <= '0;
      end else begin
         if (accept) begin
            rr_ptr_q <= grant_idx;
            id_q     <= grant_idx;
            x_q      <= bus.req_x_in[grant_idx*WIDTH +: WIDTH];
         end
         if (finish) begin
            data_q    <= bus.sqrt_result_valid_in ? bus.sqrt_result_in : '0;
            resp_id_q <= id_q;
         end
      end
   end

   assign bus.req_ready_out  = accept ? (NUM_REQ'(1) << grant_idx) : '0;
   assign bus.sqrt_valid_out = (state_q == ISSUE);
   assign bus.sqrt_x_out     = x_q;
   assign bus.resp_valid_out = (state_q == RESP);
   assign bus.resp_data_out  = data_q;
   assign bus.resp_id_out    = resp_id_q;
   assign bus.busy_out       = (state_q != IDLE);
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural sqrt stub of programmable latency.
// The timeout scenario is compiled only when SQRT_ARB_TIMEOUT_EN is defined.
module tb_sqrt_arbiter;
   localparam int W     = 12;
   localparam int N     = 4;
   localparam int L_DEF = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0, n_total = 0;
   int   cyc = 0, n_starts = 0, n_resp = 0, n_ignored = 0;
   int   stub_lat = L_DEF, stub_cnt = 0;
   logic stub_on = 1'b1;
   logic [W-1:0] stub_x = '0;

   sqrt_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

   sqrt_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.sqrt_valid_out) n_starts <= n_starts + 1;
      if (bus.resp_valid_out) n_resp <= n_resp + 1;
      if (bus.sqrt_result_valid_in && !bus.busy_out) n_ignored <= n_ignored + 1;
   end

   function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= int'(x)) r++;
      return W'(r);
   endfunction

   // Result pulse lands stub_lat cycles after the first WAIT cycle.
   initial begin
      bus.sqrt_result_valid_in = 1'b0;
      bus.sqrt_result_in       = '0;
      forever begin
         @(posedge clk); #1;
         bus.sqrt_result_valid_in = 1'b0;
         if (bus.sqrt_valid_out && stub_on) begin
            stub_x   = bus.sqrt_x_out;
            stub_cnt = stub_lat + 1;
         end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
               bus.sqrt_result_in       = isqrt(stub_x);
               bus.sqrt_result_valid_in = 1'b1;
            end
         end
      end
   end

   task automatic reset_dut();
      @(negedge clk); rst = 1'b1; bus.req_valid_in = '0;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic wait_ready(input int budget, output logic ok, output logic [N-1:0] rdy, output int at);
      ok = 1'b0; rdy = '0; at = 0;
      for (int k = 0; k < budget; k++) begin
         #1;
         if (bus.req_ready_out != '0) begin
            ok = 1'b1; rdy = bus.req_ready_out; at = cyc;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_resp(input int budget, output logic ok, output logic [W-1:0] d,
                            output logic [1:0] id, output logic e, output int at);
      ok = 1'b0; d = '0; id = '0; e = 1'b0; at = 0;
      for (int k = 0; k < budget; k++) begin
         #1;
         if (bus.resp_valid_out === 1'b1) begin
            ok = 1'b1; d = bus.resp_data_out; id = bus.resp_id_out; e = bus.resp_err_out; at = cyc;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_x_in = '1;
      bus.req_valid_in = 4'b1111;
      @(negedge clk); #1;
      n_total++;
      if ({bus.req_ready_out, bus.sqrt_valid_out, bus.sqrt_x_out} !== '0)
         $display("FAIL reset_issue_side: got ready=%b sv=%b sx=%0d want 0", bus.req_ready_out, bus.sqrt_valid_out, bus.sqrt_x_out);
      else n_pass++;
      n_total++;
      if ({bus.resp_valid_out, bus.resp_data_out, bus.resp_id_out, bus.resp_err_out} !== '0)
         $display("FAIL reset_resp_side: got rv=%b d=%0d id=%0d err=%b want 0", bus.resp_valid_out, bus.resp_data_out, bus.resp_id_out, bus.resp_err_out);
      else n_pass++;
      n_total++;
      if (bus.busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_out);
      else n_pass++;
      bus.req_valid_in = '0;
      bus.req_x_in = '0;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_single();
      logic ok; logic [N-1:0] rdy; int at, s0; logic [W-1:0] d; logic [1:0] id; logic e;
      s0 = n_starts;
      bus.req_x_in[2*W +: W] = 12'd144;
      bus.req_valid_in = 4'b0100;
      wait_ready(10, ok, rdy, at);
      n_total++;
      if (!ok || rdy !== 4'b0100) $display("FAIL single_ready: got %b (seen=%b) want 0100", rdy, ok);
      else n_pass++;
      @(negedge clk); bus.req_valid_in = '0;
      n_total++;
      if (bus.sqrt_valid_out !== 1'b1 || bus.sqrt_x_out !== 12'd144)
         $display("FAIL single_start: got sv=%b sx=%0d want 1/144", bus.sqrt_valid_out, bus.sqrt_x_out);
      else n_pass++;
      wait_resp(30, ok, d, id, e, at);
      n_total++;
      if (!ok || d !== 12'd12 || id !== 2'd2 || e !== 1'b0)
         $display("FAIL single_resp: got ok=%b d=%0d id=%0d err=%b want 1/12/2/0", ok, d, id, e);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if (bus.resp_valid_out !== 1'b0 || bus.busy_out !== 1'b0 || bus.resp_data_out !== 12'd12)
         $display("FAIL single_after: got rv=%b busy=%b d=%0d want 0/0/12", bus.resp_valid_out, bus.busy_out, bus.resp_data_out);
      else n_pass++;
      n_total++;
      if (n_starts - s0 !== 1) $display("FAIL single_starts: got %0d want 1", n_starts - s0);
      else n_pass++;
   endtask

   task automatic test_contention();
      logic ok; logic [N-1:0] rdy; int at; logic [W-1:0] d; logic [1:0] id; logic e;
      logic [N-1:0] exp_rdy [4];
      int exp_d [4];
      int exp_id [4];
      exp_rdy = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      exp_d   = '{10, 7, 63, 10};
      exp_id  = '{0, 1, 3, 0};
      reset_dut();
      bus.req_x_in = '0;
      bus.req_x_in[0*W +: W] = 12'd100;
      bus.req_x_in[1*W +: W] = 12'd50;
      bus.req_x_in[3*W +: W] = 12'd4095;
      bus.req_valid_in = 4'b1011;
      for (int k = 0; k < 4; k++) begin
         wait_ready(40, ok, rdy, at);
         n_total++;
         if (!ok || rdy !== exp_rdy[k]) $display("FAIL contention_grant%0d: got %b (seen=%b) want %b", k, rdy, ok, exp_rdy[k]);
         else n_pass++;
         if (k == 3) begin
            @(negedge clk); bus.req_valid_in = '0;
         end
         wait_resp(40, ok, d, id, e, at);
         n_total++;
         if (!ok || d !== W'(exp_d[k]) || id !== 2'(exp_id[k]))
            $display("FAIL contention_resp%0d: got ok=%b d=%0d id=%0d want %0d/%0d", k, ok, d, id, exp_d[k], exp_id[k]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic ok; logic [N-1:0] rdy; int a1, a2, at, s0; logic [W-1:0] d; logic [1:0] id; logic e;
      s0 = n_starts;
      @(negedge clk);
      bus.req_x_in[1*W +: W] = 12'd0;
      bus.req_valid_in = 4'b0010;
      wait_ready(20, ok, rdy, a1);
      n_total++;
      if (!ok || rdy !== 4'b0010) $display("FAIL b2b_grant1: got %b (seen=%b) want 0010", rdy, ok);
      else n_pass++;
      @(negedge clk); bus.req_x_in[1*W +: W] = 12'd1;
      wait_resp(30, ok, d, id, e, at);
      n_total++;
      if (!ok || d !== 12'd0 || id !== 2'd1) $display("FAIL b2b_resp1: got ok=%b d=%0d id=%0d want 0/1", ok, d, id);
      else n_pass++;
      wait_ready(20, ok, rdy, a2);
      n_total++;
      if (!ok || rdy !== 4'b0010) $display("FAIL b2b_grant2: got %b (seen=%b) want 0010", rdy, ok);
      else n_pass++;
      @(negedge clk); bus.req_valid_in = '0;
      wait_resp(30, ok, d, id, e, at);
      n_total++;
      if (!ok || d !== 12'd1 || id !== 2'd1) $display("FAIL b2b_resp2: got ok=%b d=%0d id=%0d want 1/1", ok, d, id);
      else n_pass++;
      n_total++;
      if (a2 - a1 !== 4 + stub_lat) $display("FAIL b2b_spacing: got %0d want %0d", a2 - a1, 4 + stub_lat);
      else n_pass++;
      repeat (10) @(negedge clk);
      n_total++;
      if (n_starts - s0 !== 2) $display("FAIL b2b_starts: got %0d want 2", n_starts - s0);
      else n_pass++;
   endtask

   task automatic test_reset_in_wait();
      logic ok; logic [N-1:0] rdy; int at, r0, ig0; logic [W-1:0] d; logic [1:0] id; logic e;
      stub_lat = 10;
      bus.req_x_in[0*W +: W] = 12'd2000;
      bus.req_valid_in = 4'b0001;
      wait_ready(20, ok, rdy, at);
      n_total++;
      if (!ok || rdy !== 4'b0001) $display("FAIL rstwait_grant: got %b (seen=%b) want 0001", rdy, ok);
      else n_pass++;
      @(negedge clk); bus.req_valid_in = '0;
      repeat (3) @(negedge clk);
      n_total++;
      if (bus.busy_out !== 1'b1) $display("FAIL rstwait_busy_before: got %b want 1", bus.busy_out);
      else n_pass++;
      r0 = n_resp; ig0 = n_ignored;
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      stub_lat = L_DEF;
      repeat (15) @(negedge clk);
      n_total++;
      if (n_resp !== r0) $display("FAIL rstwait_no_resp: got %0d responses want 0", n_resp - r0);
      else n_pass++;
      n_total++;
      if (n_ignored - ig0 !== 1) $display("FAIL rstwait_stale_pulse: got %0d idle pulses want 1", n_ignored - ig0);
      else n_pass++;
      n_total++;
      if (bus.busy_out !== 1'b0) $display("FAIL rstwait_busy_after: got %b want 0", bus.busy_out);
      else n_pass++;
      bus.req_x_in[3*W +: W] = 12'd16;
      bus.req_valid_in = 4'b1000;
      wait_ready(20, ok, rdy, at);
      n_total++;
      if (!ok || rdy !== 4'b1000) $display("FAIL rstwait_grant3: got %b (seen=%b) want 1000", rdy, ok);
      else n_pass++;
      @(negedge clk); bus.req_valid_in = '0;
      wait_resp(30, ok, d, id, e, at);
      n_total++;
      if (!ok || d !== 12'd4 || id !== 2'd3) $display("FAIL rstwait_resp: got ok=%b d=%0d id=%0d want 4/3", ok, d, id);
      else n_pass++;
   endtask

   task automatic test_operand_stability();
      logic ok; logic [N-1:0] rdy; int at; logic [W-1:0] d; logic [1:0] id; logic e;
      @(negedge clk);
      bus.req_x_in[0*W +: W] = 12'd81;
      bus.req_valid_in = 4'b0001;
      wait_ready(20, ok, rdy, at);
      n_total++;
      if (!ok || rdy !== 4'b0001) $display("FAIL operand_grant: got %b (seen=%b) want 0001", rdy, ok);
      else n_pass++;
      @(negedge clk);
      bus.req_x_in[0*W +: W] = 12'd9;
      bus.req_valid_in = '0;
      #1;
      n_total++;
      if (bus.sqrt_x_out !== 12'd81) $display("FAIL operand_issue_x: got %0d want 81", bus.sqrt_x_out);
      else n_pass++;
      wait_resp(30, ok, d, id, e, at);
      n_total++;
      if (!ok || d !== 12'd9 || id !== 2'd0) $display("FAIL operand_resp: got ok=%b d=%0d id=%0d want 9/0", ok, d, id);
      else n_pass++;
   endtask

`ifdef SQRT_ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic ok; logic [N-1:0] rdy; int a, r; logic [W-1:0] d; logic [1:0] id; logic e;
      stub_on = 1'b0;
      @(negedge clk);
      bus.req_x_in[2*W +: W] = 12'd500;
      bus.req_valid_in = 4'b0100;
      wait_ready(20, ok, rdy, a);
      @(negedge clk); bus.req_valid_in = '0;
      wait_resp(200, ok, d, id, e, r);
      n_total++;
      if (!ok || e !== 1'b1 || d !== 12'd0 || id !== 2'd2)
         $display("FAIL timeout_resp: got ok=%b err=%b d=%0d id=%0d want 1/1/0/2", ok, e, d, id);
      else n_pass++;
      n_total++;
      if (r - a !== 66) $display("FAIL timeout_latency: got %0d want 66", r - a);
      else n_pass++;
      stub_on = 1'b1;
      stub_lat = 63;
      @(negedge clk);
      bus.req_x_in[2*W +: W] = 12'd625;
      bus.req_valid_in = 4'b0100;
      wait_ready(20, ok, rdy, a);
      @(negedge clk); bus.req_valid_in = '0;
      wait_resp(200, ok, d, id, e, r);
      n_total++;
      if (!ok || e !== 1'b0 || d !== 12'd25) $display("FAIL timeout_race: got ok=%b err=%b d=%0d want 1/0/25", ok, e, d);
      else n_pass++;
      n_total++;
      if (r - a !== 66) $display("FAIL timeout_race_latency: got %0d want 66", r - a);
      else n_pass++;
      stub_lat = L_DEF;
   endtask
`endif

   initial begin
      bus.req_valid_in = '0;
      bus.req_x_in     = '0;
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_reset_in_wait();
      test_operand_stability();
`ifdef SQRT_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end
endmodule
